// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the unified-memory instruction sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DATA_CHK = 3'd2,
    S_DATA     = 3'd3,
    S_COMMIT   = 3'd4
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int unsigned WAIT_W          = 32;

  function automatic logic is_req_state(seq_state_e s);
    return (s == S_FETCH) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// External memory req/ack bus; the sequencer is master, the memory is slave.
interface mem_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_sequencer_wait_timer.sv
// Loadable/clearable up-counter with a terminal-count flag at a given limit.
module wait_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle FETCH / DATA / COMMIT sequencer sharing one memory port.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_mem_wr,
  input  logic              cpu_mem_rd,
  output logic [DATA_W-1:0] cpu_instr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_step,
  mem_sequencer_if.master   mem,
  output logic              bus_error,
  output logic [CNT_W-1:0]  retired
);

  localparam logic              WDOG_EN    = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  seq_state_e state, state_nxt;
  logic       in_req;
  logic       acked;
  logic       wait_tc;
  logic       timed_out;

  assign in_req    = is_req_state(state);
  assign acked     = in_req && mem.mem_ack;
  // The counter sits at TIMEOUT-1 during the TIMEOUT-th unacknowledged cycle.
  assign timed_out = WDOG_EN && in_req && !mem.mem_ack && wait_tc;

  wait_timer #(
    .W (WAIT_W)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (!in_req),
    .load     (1'b0),
    .load_val ('0),
    .en       (in_req),
    .limit    (WAIT_LIMIT),
    .tc       (wait_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    cpu_step      = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = cpu_pc;
        if (acked) begin
          state_nxt = S_DATA_CHK;
        end else if (timed_out) begin
          state_nxt = S_COMMIT;
        end
      end
      S_DATA_CHK: begin
        // Decode flags now reflect the instruction latched on the fetch ack.
        state_nxt = (cpu_mem_rd || cpu_mem_wr) ? S_DATA : S_COMMIT;
      end
      S_DATA: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = cpu_mem_wr;
        mem.mem_addr  = cpu_addr;
        mem.mem_wdata = cpu_wdata;
        if (acked || timed_out) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        cpu_step  = 1'b1;
        state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_instr <= '0;
      cpu_rdata <= '0;
      bus_error <= 1'b0;
      retired   <= '0;
    end else begin
      if ((state == S_FETCH) && acked) begin
        cpu_instr <= mem.mem_rdata;
      end
      // A simultaneous rd+wr is a store, so the load register is left alone.
      if ((state == S_DATA) && acked && cpu_mem_rd && !cpu_mem_wr) begin
        cpu_rdata <= mem.mem_rdata;
      end
      if (timed_out) begin
        bus_error <= 1'b1;
      end
      if (state == S_COMMIT) begin
        retired <= retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized bench for mem_sequencer against a per-instruction latency/result model.
module tb_mem_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 6;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_pc, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_mem_rd, cpu_mem_wr, both_flag;
  logic [DW-1:0] cpu_instr, cpu_rdata;
  logic          cpu_step, bus_error;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_sequencer #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_pc     (cpu_pc),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_mem_wr (cpu_mem_wr),
    .cpu_mem_rd (cpu_mem_rd),
    .cpu_instr  (cpu_instr),
    .cpu_rdata  (cpu_rdata),
    .cpu_step   (cpu_step),
    .mem        (mem_bus),
    .bus_error  (bus_error),
    .retired    (retired)
  );

  // Stand-in datapath decode: lw opcode 0x23, sw opcode 0x2b.
  assign cpu_mem_rd = (cpu_instr[31:26] == 6'h23) || both_flag;
  assign cpu_mem_wr = (cpu_instr[31:26] == 6'h2b);

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_instr, m_rdata;
  logic        m_berr;
  int unsigned m_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int kind);
    logic [25:0] lo;
    lo = 26'($urandom);
    case (kind)
      0:       return {6'h00, lo};
      1:       return {6'h23, lo};
      default: return {6'h2b, lo};
    endcase
  endfunction

  // kind: 0 ALU, 1 load, 2 store, 3 load+store flags together.
  // fl/dl: unacknowledged cycles before the ack; >= TO means the ack never comes.
  task automatic run_instr(input int kind, input logic [31:0] iw, input logic [31:0] pc,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int fl, input int dl,
                           input int abort_at);
    int   is_mem, is_load, is_store, f_to, d_to, exp_cyc, exp_acc;
    int   acc, waitc, step_cyc;
    logic prev_req;
    logic [31:0] exp_a;
    logic exp_we;

    check("retired_pre", 32'(retired), 32'(m_retired % (1 << CW)));
    cpu_pc    = pc;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    both_flag = (kind == 3);
    #1;

    is_load  = (kind == 1);
    is_store = (kind >= 2);
    is_mem   = (kind != 0);
    f_to     = (fl >= TO);
    d_to     = is_mem && !f_to && (dl >= TO);
    if (f_to) begin
      exp_cyc = TO + 1;
      exp_acc = 1;
    end else begin
      exp_cyc = (fl + 1) + 1 + (is_mem ? (d_to ? TO : dl + 1) : 0) + 1;
      exp_acc = is_mem ? 2 : 1;
    end

    acc = -1; waitc = 0; prev_req = 1'b0; step_cyc = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (abort_at == cyc) return;
      if (cpu_step) begin
        step_cyc = cyc;
        break;
      end
      if (mem_bus.mem_req) begin
        if (!prev_req) begin
          acc++;
          waitc = 0;
        end
        exp_a  = (acc == 0) ? pc : addr;
        exp_we = (acc == 0) ? 1'b0 : is_store[0];
        check("mem_addr", mem_bus.mem_addr, exp_a);
        check("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
        if (acc > 0) check("mem_wdata", mem_bus.mem_wdata, wdata);
        if (waitc == ((acc == 0) ? fl : dl)) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = (acc == 0) ? iw : rdata;
        end else begin
          mem_bus.mem_ack   = 1'b0;
          mem_bus.mem_rdata = $urandom;
        end
        waitc++;
      end else begin
        check("idle_we", 32'(mem_bus.mem_we), 32'd0);
        mem_bus.mem_ack   = ($urandom_range(0, 3) == 0);
        mem_bus.mem_rdata = $urandom;
      end
      prev_req = mem_bus.mem_req;
      @(negedge clk); #1;
    end

    check("step_cycle", step_cyc, exp_cyc);
    check("accesses", acc + 1, exp_acc);
    if (!f_to) m_instr = iw;
    if (f_to || d_to) m_berr = 1'b1;
    if (!f_to && is_load && !d_to) m_rdata = rdata;
    m_retired++;
    check("commit_req", 32'(mem_bus.mem_req), 32'd0);
    check("cpu_instr", cpu_instr, m_instr);
    check("cpu_rdata", cpu_rdata, m_rdata);
    check("bus_error", 32'(bus_error), 32'(m_berr));
    mem_bus.mem_ack   = $urandom_range(0, 1);
    mem_bus.mem_rdata = $urandom;
    @(negedge clk); #1;
  endtask

  // Async reset, stray acks during and right after it, then land in the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_addr", mem_bus.mem_addr, 32'd0);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst_step", 32'(cpu_step), 32'd0);
    check("rst_instr", cpu_instr, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);
    m_instr = '0; m_rdata = '0; m_berr = 1'b0; m_retired = 0;
    for (int i = 0; i < 3; i++) begin
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = $urandom;
      @(negedge clk);
    end
    #1;
    reset = 1'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = $urandom;
    check("idle_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk); #1;
    check("stray_instr", cpu_instr, 32'd0);
    check("stray_rdata", cpu_rdata, 32'd0);
  endtask

  task automatic run_random(input int n);
    int kind, fl, dl;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      fl   = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 3);
      dl   = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
      run_instr(kind, mk_instr(kind), $urandom & 32'hffff_fffc, $urandom,
                $urandom, $urandom, fl, dl, 0);
    end
  endtask

  initial begin
    cpu_pc = '0; cpu_addr = '0; cpu_wdata = '0; both_flag = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    m_instr = '0; m_rdata = '0; m_berr = 1'b0; m_retired = 0;
    do_reset();

    run_instr(0, 32'h0022_0820, 32'h0000_0000, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
    run_instr(1, mk_instr(1), 32'h0000_0004, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_instr(2, mk_instr(2), 32'h0000_0008, 32'h0000_0100, 32'h0000_00AB, 32'h1234_5678, 0, 5, 0);
    run_instr(3, mk_instr(3), 32'h0000_000C, 32'h0000_0104, 32'h0000_0055, 32'hCAFE_F00D, 1, 1, 0);
    run_instr(0, mk_instr(0), 32'h0000_0010, 32'h0, 32'h0, 32'h0, TO + 3, 0, 0);
    run_instr(1, mk_instr(1), 32'h0000_0014, 32'h0000_0300, 32'h0, 32'h0BAD_0BAD, 1, 99, 0);
    run_instr(1, mk_instr(1), 32'h0000_0018, 32'h0000_0304, 32'h0, 32'h600D_600D, 2, 0, 0);
    run_instr(0, mk_instr(0), 32'h0000_001C, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    run_instr(1, mk_instr(1), 32'h0000_0020, 32'h0000_0400, 32'h0, 32'h0, 0, 10, 4);
    do_reset();
    run_instr(0, mk_instr(0), 32'h0000_0080, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    run_random(16);
    check("retired_wrap", 32'(retired), 32'd1);
    run_random(40);
    check("retired_final", 32'(retired), 32'(m_retired % (1 << CW)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
